// File: rtl/sar_comparator_ctrl.sv
// Successive-approximation sequencer driving a dynamic comparator and reference DAC.
// Optional macro SAR_MAJORITY_VOTE_EN: three EVAL/DECIDE votes per bit, bit kept on a 2-of-3 majority.

module sar_comparator_ctrl #(
  parameter int N_BITS     = 8,
  parameter int SAMPLE_CYC = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_decision,
  output logic              sample,
  output logic              cmp_rst,
  output logic              cmp_eval,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int CNT_MAX = ((SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC) - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(N_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [BIT_W-1:0]    bit_r, bit_s;
  logic [N_BITS-1:0]   work_r, work_s;
  logic [N_BITS-1:0]   dac_s, result_s, mask_s;
  logic                keep_s, resolve_s;
`ifdef SAR_MAJORITY_VOTE_EN
  logic [1:0]          vote_r, vote_s, ones_r, ones_s;
`endif

  // Next-state, working-code and trial-code computation
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    work_s    = work_r;
    dac_s     = dac_code;
    result_s  = result;
    keep_s    = 1'b0;
    resolve_s = 1'b0;
    mask_s    = N_BITS'(1) << bit_r;
`ifdef SAR_MAJORITY_VOTE_EN
    vote_s    = vote_r;
    ones_s    = ones_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SAMPLE;
          cnt_s   = '0;
          work_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (cnt_r == CNT_W'(SAMPLE_CYC - 1)) begin
          state_s = ST_SETTLE;
          cnt_s   = '0;
          bit_s   = BIT_W'(N_BITS - 1);
          dac_s   = {1'b1, {(N_BITS-1){1'b0}}};
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_W'(SETTLE_CYC - 1)) begin
          state_s = ST_EVAL;
          cnt_s   = '0;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        state_s = ST_DECIDE;
      end
      ST_DECIDE: begin
`ifdef SAR_MAJORITY_VOTE_EN
        // Re-evaluate without re-settling until the third vote is in
        if (vote_r != 2'd2) begin
          vote_s    = vote_r + 2'd1;
          ones_s    = ones_r + {1'b0, cmp_decision};
          resolve_s = 1'b0;
          keep_s    = 1'b0;
        end else begin
          vote_s    = 2'd0;
          ones_s    = 2'd0;
          resolve_s = 1'b1;
          keep_s    = ((ones_r + {1'b0, cmp_decision}) >= 2'd2);
        end
`else
        resolve_s = 1'b1;
        keep_s    = cmp_decision;
`endif
        if (!resolve_s) begin
          state_s = ST_EVAL;
        end else begin
          work_s = keep_s ? (work_r | mask_s) : work_r;
          if (bit_r == '0) begin
            state_s  = ST_DONE;
            result_s = work_s;
          end else begin
            bit_s   = bit_r - BIT_W'(1);
            dac_s   = work_s | (mask_s >> 1);
            state_s = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        dac_s   = '0;
      end
      default: begin
        state_s = ST_IDLE;
        dac_s   = '0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      bit_r    <= BIT_W'(N_BITS - 1);
      work_r   <= '0;
      sample   <= 1'b0;
      cmp_rst  <= 1'b1;
      cmp_eval <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
`ifdef SAR_MAJORITY_VOTE_EN
      vote_r   <= 2'd0;
      ones_r   <= 2'd0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      work_r   <= work_s;
      sample   <= (state_s == ST_SAMPLE);
      cmp_rst  <= (state_s != ST_EVAL);
      cmp_eval <= (state_s == ST_EVAL);
      dac_code <= dac_s;
      busy     <= (state_s != ST_IDLE);
      done     <= (state_s == ST_DONE);
      result   <= result_s;
`ifdef SAR_MAJORITY_VOTE_EN
      vote_r   <= vote_s;
      ones_r   <= ones_s;
`endif
    end
  end

endmodule

// File: tb/tb_sar_comparator_ctrl.sv
// Self-checking bench for sar_comparator_ctrl: table vectors, random conversions against a
// binary-search reference model, and hand-written reset / back-to-back sequences.

module tb_sar_comparator_ctrl;

  localparam int N      = 8;
  localparam int SAMP   = 2;
  localparam int SETL   = 2;
`ifdef SAR_MAJORITY_VOTE_EN
  localparam int VOTES  = 3;
`else
  localparam int VOTES  = 1;
`endif
  localparam int LAT    = SAMP + N * (SETL + 2 * VOTES) + 1;
  localparam int LIMIT  = 2 * LAT + 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cmp_decision = 1'b0;
  logic         sample, cmp_rst, cmp_eval, busy, done;
  logic [N-1:0] dac_code, result;

  sar_comparator_ctrl #(.N_BITS(N), .SAMPLE_CYC(SAMP), .SETTLE_CYC(SETL)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp_decision(cmp_decision),
    .sample(sample), .cmp_rst(cmp_rst), .cmp_eval(cmp_eval), .dac_code(dac_code),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  int           viol = 0;
  int           done_cnt = 0;
  int           flip_idx = -1;
  bit           noisy = 1'b0;
  logic [N-1:0] cur_vin = '0;
  logic [N-1:0] trial_q[$];
  bit           dec_q[$];

  typedef struct {
    logic [N-1:0] vin;
    logic [N-1:0] exp_res;
    bit           pulse;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp_v);
    end
  endtask

  // One clock; observes outputs #1 after the edge and plays the comparator for the next cycle
  task automatic tick();
    logic e;
    bit   d;
    e = cmp_eval;
    @(posedge clk);
    #1;
    if (cmp_eval && (cmp_rst || sample)) viol++;
    if (cmp_eval) trial_q.push_back(dac_code);
    if (done) done_cnt++;
    if (e === 1'b1) begin
      d = noisy ? 1'($urandom_range(0, 1)) : (cur_vin >= dac_code);
      if (flip_idx == dec_q.size()) d = ~d;
      dec_q.push_back(d);
      cmp_decision = d;
    end else begin
      cmp_decision = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_conv(input logic [N-1:0] vin, input logic [N-1:0] exp_res,
                          input bit chk, input bit pulse, input string name);
    int           lat, busy_low, d0, idx, tmis, ones;
    logic [N-1:0] res, accum;
    cur_vin = vin;
    trial_q.delete();
    dec_q.delete();
    d0 = done_cnt;
    lat = -1;
    busy_low = 0;
    res = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= LIMIT; n++) begin
      if (!busy) busy_low++;
      if (done) begin
        lat = n;
        res = result;
        break;
      end
      start = pulse && (n == 5);
      tick();
    end
    start = pulse;
    tick();
    start = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " busy"}, 64'(busy_low), 64'd0);
    check({name, " idle_after"}, {62'd0, busy, done}, 64'd0);
    check({name, " dac_idle"}, 64'(dac_code), 64'd0);
    repeat (3) tick();
    check({name, " start_ignored"}, {63'd0, busy}, 64'd0);
    check({name, " done_count"}, 64'(done_cnt - d0), 64'd1);
    // Reference: binary search where each bit is decided by majority of its decisions
    accum = '0;
    idx = 0;
    tmis = 0;
    for (int b = N - 1; b >= 0; b--) begin
      ones = 0;
      for (int v = 0; v < VOTES; v++) begin
        if (idx >= trial_q.size() || trial_q[idx] != (accum | (N'(1) << b))) tmis++;
        if (idx < dec_q.size() && dec_q[idx]) ones++;
        idx++;
      end
      if (2 * ones > VOTES) accum = accum | (N'(1) << b);
    end
    check({name, " trial_count"}, 64'(trial_q.size()), 64'(N * VOTES));
    check({name, " trials"}, 64'(tmis), 64'd0);
    check({name, " model_result"}, 64'(res), 64'(accum));
    if (chk) check({name, " result"}, 64'(res), 64'(exp_res));
  endtask

  vec_t         vecs[6];
  int           dq[$];
  int           w;
  logic [N-1:0] rv;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{8'h5A, 8'h5A, 1'b1};
    vecs[4] = '{8'h3C, 8'h3C, 1'b1};
    vecs[5] = '{8'h81, 8'h81, 1'b0};

    // Reset held, then idle with start low
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("reset_vals", {43'd0, sample, cmp_rst, cmp_eval, busy, done, dac_code, result},
            {43'd0, 5'b01000, 8'h00, 8'h00});
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      check("idle_vals", {43'd0, sample, cmp_rst, cmp_eval, busy, done, dac_code, result},
            {43'd0, 5'b01000, 8'h00, 8'h00});
    end

    // Explicit trial sequence for A5
    run_conv(8'hA5, 8'hA5, 1'b1, 1'b0, "a5");
    check("a5_first_trials", {trial_q[0], trial_q[VOTES], trial_q[2*VOTES], trial_q[3*VOTES]},
          64'h80C0A0B0);
    check("a5_last_trials", {trial_q[4*VOTES], trial_q[5*VOTES], trial_q[6*VOTES], trial_q[7*VOTES]},
          64'hA8A4A6A5);

    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].vin, vecs[i].exp_res, 1'b1, vecs[i].pulse, $sformatf("vec%0d", i));
    end

    // Reset in the 10th cycle of a conversion
    cur_vin = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_vals", {43'd0, sample, cmp_rst, cmp_eval, busy, done, dac_code, result},
          {43'd0, 5'b01000, 8'h00, 8'h00});
    w = done_cnt;
    repeat (40) tick();
    check("midrst_no_done", 64'(done_cnt - w), 64'd0);
    run_conv(8'h5A, 8'h5A, 1'b1, 1'b0, "after_rst");

    // start held high: back-to-back conversions
    cur_vin = 8'h3C;
    start = 1'b1;
    for (int n = 1; n <= 3 * (LAT + 1) + 2; n++) begin
      tick();
      if (done) dq.push_back(n);
    end
    start = 1'b0;
    w = 0;
    while (busy && w < LIMIT) begin
      tick();
      w++;
    end
    check("b2b_drained", {63'd0, busy}, 64'd0);
    check("b2b_count", 64'(dq.size() >= 3), 64'd1);
    if (dq.size() >= 3) begin
      check("b2b_first", 64'(dq[0]), 64'(LAT));
      check("b2b_gap1", 64'(dq[1] - dq[0]), 64'(LAT + 1));
      check("b2b_gap2", 64'(dq[2] - dq[1]), 64'(LAT + 1));
    end
    check("b2b_result", 64'(result), 64'h3C);

`ifdef SAR_MAJORITY_VOTE_EN
    flip_idx = 1;
    run_conv(8'hC3, 8'hC3, 1'b1, 1'b0, "vote_flip");
    flip_idx = -1;
`endif

    // Random inputs with an ideal comparator
    noisy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rv = N'($urandom);
      run_conv(rv, rv, 1'b1, 1'(i % 2), $sformatf("rand_ideal%0d", i));
    end
    // Random comparator decisions; only the model result is known
    noisy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rv = N'($urandom);
      run_conv(rv, '0, 1'b0, 1'(i % 2), $sformatf("rand_noisy%0d", i));
    end
    noisy = 1'b0;

    check("eval_rst_sample_excl", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
